// File: rtl/bus_slave_if.sv
// bus_slave_if
// Slave-side handshake for a simple strobed bus. A selected address strobe
// is accepted in IDLE. It is then held for WAIT_CYCLES optional wait states,
// turned into one local read or write pulse, and answered with a one-cycle
// active-low ready carrying the read data.
`timescale 1ns/1ps

module bus_slave_if #(
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rdy_,
    output logic              busy,
    output logic [ADDR_W-1:0] loc_addr,
    output logic              loc_re,
    output logic              loc_we,
    output logic [DATA_W-1:0] loc_wr_data,
    input  logic [DATA_W-1:0] loc_rd_data
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        READY
    } state_t;

    // Value loaded into the wait counter on accept. With no wait states the
    // counter is never used, so its load value is pinned to zero.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t            state;
    logic [3:0]        wait_cnt;
    logic              lat_rw;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wr_data;

    // Transaction sequencer. It owns all registered outputs so that each pulse
    // is set on the edge that enters its state and cleared on the edge that
    // leaves it. Reset abandons any transaction, so no late pulse can escape.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            lat_rw      <= 1'b1;
            lat_addr    <= '0;
            lat_wr_data <= '0;
            loc_re      <= 1'b0;
            loc_we      <= 1'b0;
            rdy_        <= 1'b1;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!cs_ && !as_) begin
                        lat_rw      <= rw;
                        lat_addr    <= addr;
                        lat_wr_data <= wr_data;
                        busy        <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state  <= ACCESS;
                            loc_re <= rw;
                            loc_we <= ~rw;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state  <= ACCESS;
                        loc_re <= lat_rw;
                        loc_we <= ~lat_rw;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ACCESS: begin
                    state  <= READY;
                    loc_re <= 1'b0;
                    loc_we <= 1'b0;
                    rdy_   <= 1'b0;
                end
                READY: begin
                    state <= IDLE;
                    rdy_  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    loc_re <= 1'b0;
                    loc_we <= 1'b0;
                    rdy_   <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    // The local memory returns read data in the READY cycle, one cycle after
    // loc_re. That data is therefore steered to the bus combinationally
    // instead of being registered again. Writes answer with zero.
    always_comb begin
        rd_data = '0;
        if (!rdy_ && lat_rw) begin
            rd_data = loc_rd_data;
        end
    end

    assign loc_addr    = lat_addr;
    assign loc_wr_data = lat_wr_data;

endmodule

// File: tb/tb_bus_slave_if.sv
// tb_bus_slave_if
// Three slaves with 0, 3 and 5 wait states share one clock and reset.
// Directed transactions push their expected local pulse and ready response
// into queues. A monitor pops those entries whenever a slave shows loc_re,
// loc_we or rdy_.
`timescale 1ns/1ps

module tb_bus_slave_if;

    localparam int NDUT = 3;

    typedef struct {
        int          dut;
        bit          we;
        logic [29:0] a;
        logic [31:0] d;
        int          cyc;
    } loc_exp_t;

    typedef struct {
        int          dut;
        logic [31:0] d;
        int          cyc;
    } rdy_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs_n        [NDUT];
    logic        as_n        [NDUT];
    logic        rw          [NDUT];
    logic [29:0] addr        [NDUT];
    logic [31:0] wr_data     [NDUT];
    logic [31:0] rd_data     [NDUT];
    logic        rdy_n       [NDUT];
    logic        busy        [NDUT];
    logic [29:0] loc_addr    [NDUT];
    logic        loc_re      [NDUT];
    logic        loc_we      [NDUT];
    logic [31:0] loc_wr_data [NDUT];
    logic [31:0] loc_rd_data [NDUT];
    logic [31:0] rd_value;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    loc_exp_t loc_q[$];
    rdy_exp_t rdy_q[$];

    // 100 MHz clock; cycle number advances on each rising edge
    always #5 clk = ~clk;

    // Cycle counter used to timestamp stimulus and observed pulses
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int WC = (g == 0) ? 0 : (g == 1) ? 3 : 5;
        bus_slave_if #(.ADDR_W(30), .DATA_W(32), .WAIT_CYCLES(WC)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .cs_        (cs_n[g]),
            .as_        (as_n[g]),
            .rw         (rw[g]),
            .addr       (addr[g]),
            .wr_data    (wr_data[g]),
            .rd_data    (rd_data[g]),
            .rdy_       (rdy_n[g]),
            .busy       (busy[g]),
            .loc_addr   (loc_addr[g]),
            .loc_re     (loc_re[g]),
            .loc_we     (loc_we[g]),
            .loc_wr_data(loc_wr_data[g]),
            .loc_rd_data(loc_rd_data[g])
        );
    end

    // Synchronous-read memory model: data is valid the cycle after loc_re,
    // and garbage otherwise, so an early sample of loc_rd_data is visible
    always @(posedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            loc_rd_data[g] <= loc_re[g] ? rd_value : 32'h0BAD_0BAD;
        end
    end

    function automatic int wc(input int g);
        return (g == 0) ? 0 : (g == 1) ? 3 : 5;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Issue one strobe on slave g during the current cycle and, if a
    // response is expected, queue the local pulse and ready it must produce
    task automatic applyStimulus(input int g, input bit is_read, input logic [29:0] a,
                                 input logic [31:0] d, input logic [31:0] rd_exp,
                                 input bit expect_resp);
        loc_exp_t le;
        rdy_exp_t re;
        if (expect_resp) begin
            le.dut = g; le.we = !is_read; le.a = a; le.d = d; le.cyc = cyc + 1 + wc(g);
            re.dut = g; re.d = is_read ? rd_exp : 32'h0; re.cyc = cyc + 2 + wc(g);
            loc_q.push_back(le);
            rdy_q.push_back(re);
        end
        cs_n[g] = 1'b0;
        as_n[g] = 1'b0;
        rw[g] = is_read;
        addr[g] = a;
        wr_data[g] = d;
        @(posedge clk); #1;
        cs_n[g] = 1'b1;
        as_n[g] = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: every local pulse and every ready cycle must match the oldest
    // queued expectation; anything unexpected counts as a failure
    always @(negedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            if (loc_re[g] || loc_we[g]) begin
                checkOutput("loc_exclusive", 64'(loc_re[g] & loc_we[g]), 64'h0);
                if (loc_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL unexpected_loc: dut=%0d actual=pulse required=none at cycle %0d", g, cyc);
                end else begin
                    loc_exp_t e;
                    e = loc_q.pop_front();
                    checkOutput("loc_dut", 64'(g), 64'(e.dut));
                    checkOutput("loc_cycle", 64'(cyc), 64'(e.cyc));
                    checkOutput("loc_we", 64'(loc_we[g]), 64'(e.we));
                    checkOutput("loc_addr", 64'(loc_addr[g]), 64'(e.a));
                    if (e.we) checkOutput("loc_wr_data", 64'(loc_wr_data[g]), 64'(e.d));
                end
            end
            if (!rdy_n[g]) begin
                if (rdy_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL unexpected_rdy: dut=%0d actual=rdy required=none at cycle %0d", g, cyc);
                end else begin
                    rdy_exp_t e;
                    e = rdy_q.pop_front();
                    checkOutput("rdy_dut", 64'(g), 64'(e.dut));
                    checkOutput("rdy_cycle", 64'(cyc), 64'(e.cyc));
                    checkOutput("rd_data", 64'(rd_data[g]), 64'(e.d));
                end
            end
        end
    end

    // Watchdog: the directed sequence is short, so this only trips on a hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        int n;
        reset = 1'b1;
        rd_value = 32'h0;
        for (int g = 0; g < NDUT; g++) begin
            cs_n[g] = 1'b1; as_n[g] = 1'b1; rw[g] = 1'b0; addr[g] = '0; wr_data[g] = '0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] reset state");
        for (int g = 0; g < NDUT; g++) begin
            checkOutput("rst_rdy", 64'(rdy_n[g]), 64'h1);
            checkOutput("rst_busy", 64'(busy[g]), 64'h0);
            checkOutput("rst_rd_data", 64'(rd_data[g]), 64'h0);
            checkOutput("rst_loc_re", 64'(loc_re[g]), 64'h0);
            checkOutput("rst_loc_we", 64'(loc_we[g]), 64'h0);
            checkOutput("rst_loc_addr", 64'(loc_addr[g]), 64'h0);
            checkOutput("rst_loc_wr_data", 64'(loc_wr_data[g]), 64'h0);
        end
        idle(2);

        $display("[TB] zero-wait read");
        rd_value = 32'hDEAD_BEEF;
        applyStimulus(0, 1'b1, 30'h10, 32'h0, 32'hDEAD_BEEF, 1'b1);
        checkOutput("read_busy_c1", 64'(busy[0]), 64'h1);
        idle(2);
        checkOutput("read_busy_c3", 64'(busy[0]), 64'h0);
        idle(3);

        $display("[TB] three-wait write");
        applyStimulus(1, 1'b0, 30'h2A, 32'h1234_5678, 32'h0, 1'b1);
        checkOutput("write_busy_c1", 64'(busy[1]), 64'h1);
        idle(8);

        $display("[TB] unselected strobe and strobe during wait");
        cs_n[1] = 1'b1; as_n[1] = 1'b0; rw[1] = 1'b1; addr[1] = 30'h3F;
        idle(1);
        as_n[1] = 1'b1;
        checkOutput("unsel_busy", 64'(busy[1]), 64'h0);
        idle(2);
        applyStimulus(1, 1'b0, 30'h07, 32'h77, 32'h0, 1'b1);
        cs_n[1] = 1'b0; as_n[1] = 1'b0; rw[1] = 1'b1; addr[1] = 30'h09;
        idle(1);
        cs_n[1] = 1'b1; as_n[1] = 1'b1;
        idle(10);

        $display("[TB] back-to-back write then read");
        applyStimulus(0, 1'b0, 30'h3, 32'h1, 32'h0, 1'b1);
        idle(2);
        rd_value = 32'h0000_CAFE;
        applyStimulus(0, 1'b1, 30'h4, 32'h0, 32'h0000_CAFE, 1'b1);
        idle(5);

        $display("[TB] inputs changed after accept");
        applyStimulus(0, 1'b0, 30'h5, 32'hA5, 32'h0, 1'b1);
        addr[0] = 30'h3FFF_FFFF; wr_data[0] = 32'hFFFF_FFFF; rw[0] = 1'b1;
        idle(4);
        applyStimulus(1, 1'b0, 30'h6, 32'hA5, 32'h0, 1'b1);
        addr[1] = 30'h3FFF_FFFF; wr_data[1] = 32'hFFFF_FFFF; rw[1] = 1'b1;
        idle(8);
        rw[0] = 1'b0; rw[1] = 1'b0;

        $display("[TB] reset abandons a five-wait write");
        applyStimulus(2, 1'b0, 30'h11, 32'h55, 32'h0, 1'b0);
        idle(1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        checkOutput("abandon_loc_addr", 64'(loc_addr[2]), 64'h0);
        for (int i = 0; i < 10; i++) begin
            checkOutput("abandon_rdy", 64'(rdy_n[2]), 64'h1);
            checkOutput("abandon_busy", 64'(busy[2]), 64'h0);
            idle(1);
        end

        $display("[TB] strobe coincident with reset");
        reset = 1'b1;
        cs_n[0] = 1'b0; as_n[0] = 1'b0; rw[0] = 1'b0; addr[0] = 30'h22; wr_data[0] = 32'h99;
        idle(1);
        reset = 1'b0;
        cs_n[0] = 1'b1; as_n[0] = 1'b1;
        checkOutput("rst_strobe_busy", 64'(busy[0]), 64'h0);
        checkOutput("rst_strobe_loc_addr", 64'(loc_addr[0]), 64'h0);
        idle(6);

        n = loc_q.size();
        checkOutput("loc_queue_drained", 64'(n), 64'h0);
        n = rdy_q.size();
        checkOutput("rdy_queue_drained", 64'(n), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
